// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared defaults for the partial-sum output FIFO slice.
//   COL_DEF     - default number of independent column FIFOs
//   PSUM_BW_DEF - default bits per column entry
//   DEPTH_DEF   - default entries per column (power of two, >= 2)
//   ofifo_aw()  - pointer width derived from the depth
package ofifo_pkg;

    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF   = 64;

    function automatic int ofifo_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/psum_ofifo_if.sv
// psum_ofifo_if: bundle of the row FIFO data/handshake signals.
//   master modport : producer/consumer side (drives in, wr, rd, afull_thresh, clr_err)
//   slave modport  : the FIFO itself (drives out and all status flags)
//
// Handshake: a column write is taken on a rising edge when wr[i] is high and
// the column has room (o_ready means no column is full; a full column still
// takes a write when a row read is accepted on the same edge). A row read is
// taken on a rising edge when rd && o_valid; the row appears on out with
// o_out_vld high for exactly the following cycle. rd while o_valid is low is
// ignored and flagged on o_udf.
interface psum_ofifo_if import ofifo_pkg::*; #(
    parameter int COL     = COL_DEF,
    parameter int PSUM_BW = PSUM_BW_DEF,
    parameter int DEPTH   = DEPTH_DEF
);
    localparam int AW = ofifo_aw(DEPTH);

    logic [COL*PSUM_BW-1:0] in;
    logic [COL-1:0]         wr;
    logic                   rd;
    logic [AW:0]            afull_thresh;
    logic                   clr_err;
    logic [COL*PSUM_BW-1:0] out;
    logic                   o_out_vld;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_afull;
    logic [AW:0]            o_rows;
    logic                   o_ovf;
    logic                   o_udf;

    modport master (
        output in, wr, rd, afull_thresh, clr_err,
        input  out, o_out_vld, o_valid, o_full, o_ready, o_afull, o_rows, o_ovf, o_udf
    );

    modport slave (
        input  in, wr, rd, afull_thresh, clr_err,
        output out, o_out_vld, o_valid, o_full, o_ready, o_afull, o_rows, o_ovf, o_udf
    );

endinterface

// File: rtl/ofifo_col.sv
// ofifo_col: one column of the output FIFO.
//   clk, reset : clock, synchronous active-high reset
//   wr, din    : write strobe and data for this column
//   rd_acc     : row read accepted (driven by the top; only high when non-empty)
//   dout       : head entry (combinational view of mem[rptr])
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
//   wr_drop    : write refused because the column is full and no read frees a slot
module ofifo_col import ofifo_pkg::*; #(
    parameter int  PSUM_BW = PSUM_BW_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    localparam int AW      = ofifo_aw(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [PSUM_BW-1:0] din,
    input  logic               rd_acc,
    output logic [PSUM_BW-1:0] dout,
    output logic [AW:0]        count,
    output logic               full,
    output logic               empty,
    output logic               wr_drop
);

    logic [PSUM_BW-1:0] mem [DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic               wr_acc;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A full column can still take a write if the same edge pops a row.
    assign wr_acc  = wr && (!full || rd_acc);
    assign wr_drop = wr && full && !rd_acc;
    assign dout    = mem[rptr];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc)
            mem[wptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (rd_acc)
                rptr <= rptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo: COL parallel column FIFOs read out as aligned rows.
//   clk, reset : clock, synchronous active-high reset
//   bus        : psum_ofifo_if slave modport
//       in/wr         - per-column data and write strobes
//       rd            - row read request, accepted when o_valid
//       afull_thresh  - almost-full level compared against every column count
//       clr_err       - clears the sticky o_ovf/o_udf flags
//       out/o_out_vld - registered row and its one-cycle valid pulse
//       o_valid       - every column holds at least one entry
//       o_full/o_ready, o_afull, o_rows - occupancy status
//       o_ovf/o_udf   - sticky overflow / underflow
module psum_ofifo import ofifo_pkg::*; #(
    parameter int  COL     = COL_DEF,
    parameter int  PSUM_BW = PSUM_BW_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    localparam int AW      = ofifo_aw(DEPTH)
) (
    input logic         clk,
    input logic         reset,
    psum_ofifo_if.slave bus
);

    logic [COL*PSUM_BW-1:0] head_row;
    logic [AW:0]            cnt [COL];
    logic [COL-1:0]         col_full;
    logic [COL-1:0]         col_empty;
    logic [COL-1:0]         col_drop;
    logic                   rd_acc;
    logic                   udf_evt;
    logic                   ovf_evt;
    logic [AW:0]            rows_min;
    logic                   afull_any;

    for (genvar i = 0; i < COL; i++) begin : g_col
        ofifo_col #(
            .PSUM_BW (PSUM_BW),
            .DEPTH   (DEPTH)
        ) u_col (
            .clk     (clk),
            .reset   (reset),
            .wr      (bus.wr[i]),
            .din     (bus.in[PSUM_BW*i +: PSUM_BW]),
            .rd_acc  (rd_acc),
            .dout    (head_row[PSUM_BW*i +: PSUM_BW]),
            .count   (cnt[i]),
            .full    (col_full[i]),
            .empty   (col_empty[i]),
            .wr_drop (col_drop[i])
        );
    end

    // A row is only readable when every column has data, so the read is
    // judged on the counts before this edge's writes land.
    assign bus.o_valid = ~|col_empty;
    assign rd_acc      = bus.rd && bus.o_valid;
    assign udf_evt     = bus.rd && !bus.o_valid;
    assign ovf_evt     = |col_drop;
    assign bus.o_full  = |col_full;
    assign bus.o_ready = ~|col_full;
    assign bus.o_afull = afull_any;
    assign bus.o_rows  = rows_min;

    always_comb begin
        rows_min  = cnt[0];
        afull_any = 1'b0;
        for (int i = 0; i < COL; i++) begin
            if (cnt[i] < rows_min)
                rows_min = cnt[i];
            if (cnt[i] >= bus.afull_thresh)
                afull_any = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out       <= '0;
            bus.o_out_vld <= 1'b0;
        end else begin
            bus.o_out_vld <= rd_acc;
            if (rd_acc)
                bus.out <= head_row;
        end
    end

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.o_ovf <= 1'b0;
            bus.o_udf <= 1'b0;
        end else begin
            if (ovf_evt)
                bus.o_ovf <= 1'b1;
            else if (bus.clr_err)
                bus.o_ovf <= 1'b0;
            if (udf_evt)
                bus.o_udf <= 1'b1;
            else if (bus.clr_err)
                bus.o_udf <= 1'b0;
        end
    end

endmodule

// File: doc/psum_ofifo.md
PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 SHALL have parameter COL, default 8: number of independent column FIFOs.
REQ-002 SHALL have parameter PSUM_BW, default 16: bits per column entry.
REQ-003 SHALL have parameter DEPTH, default 64: entries per column; power of two, at least 2; AW = clog2(DEPTH).
REQ-004 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in, input, COL*PSUM_BW: column i data at slice [PSUM_BW*(i+1)-1 : PSUM_BW*i].
REQ-007 SHALL have port wr, input, COL: per-column write strobe.
REQ-008 SHALL have port rd, input, 1: row read request.
REQ-009 SHALL have port afull_thresh, input, AW+1: almost-full level.
REQ-010 SHALL have port clr_err, input, 1: clears the sticky error flags.
REQ-011 SHALL have port out, output, COL*PSUM_BW: registered row output.
REQ-012 SHALL have port o_out_vld, output, 1: out holds a newly read row.
REQ-013 SHALL have port o_valid, output, 1: a complete row is readable.
REQ-014 SHALL have port o_full / o_ready, output, 1 each: any column full / no column full.
REQ-015 SHALL have port o_afull, output, 1: some column count >= afull_thresh.
REQ-016 SHALL have port o_rows, output, AW+1: minimum occupancy across columns.
REQ-017 SHALL have port o_ovf / o_udf, output, 1 each: sticky overflow / underflow.

Function
REQ-018 SHALL keep, per column, a write pointer, a read pointer (AW bits, wrapping DEPTH-1 -> 0) and a count (AW+1 bits, 0..DEPTH).
REQ-019 SHALL accept wr[i] when count[i] < DEPTH, or when count[i] == DEPTH and a row read is accepted in the same cycle; accepted data is stored at wptr[i] and wptr[i] increments.
REQ-020 SHALL drop any other write to a full column, leave that column's state unchanged, and set o_ovf.
REQ-021 SHALL drive o_valid combinationally high only when every column count is nonzero, so rows are aligned across all COL columns.
REQ-022 SHALL accept a read when rd && o_valid: all read pointers increment together, and the head row is registered into out at that clock edge.
REQ-023 SHALL pulse o_out_vld high for the cycle after an accepted read; read latency is 1 cycle; out holds its value until the next accepted read.
REQ-024 SHALL ignore rd when o_valid is low and set o_udf; a write to an empty column in the same cycle does not make that read valid.
REQ-025 SHALL update each count as +1 for an accepted write only, -1 for an accepted read only, and unchanged when both occur.
REQ-026 SHALL derive o_full, o_ready, o_afull and o_rows combinationally from the current counts.
REQ-027 SHALL hold o_ovf and o_udf until clr_err; if clr_err coincides with a new error, the flag stays set.
REQ-028 SHALL sustain back-to-back reads, one row per cycle, while o_valid holds.

Reset
REQ-029 SHALL, on reset, clear all pointers and counts, out, o_out_vld, o_ovf and o_udf to 0; o_valid=0, o_full=0, o_ready=1, o_rows=0.
REQ-030 SHALL, on reset mid-operation, discard all stored contents and ignore wr/rd in that cycle; storage RAM contents need not be cleared.

Structure
REQ-031 SHALL place the defaults for COL, PSUM_BW and DEPTH, and the AW derivation, in shared package ofifo_pkg.
REQ-032 SHALL use one sub-module, ofifo_col: a single-column FIFO with pointers, count, full/empty, and a read-accept input driven by the top level.
REQ-033 SHALL keep row-read arbitration, the output register, the minimum-occupancy reduction and the error flags in psum_ofifo.

Verification (COL=4, PSUM_BW=16, DEPTH=8)
REQ-034 SHALL cover skewed fill: wr=4'b0001 then 0011, 0111, 1111 on successive cycles with in=0x0001_0002_0003_0004 -> o_valid rises only after the 1111 cycle, o_rows=1; rd gives out=that row with o_out_vld one cycle later.
REQ-035 SHALL cover full and overflow: 8 all-column writes -> o_full=1, o_ready=0; a 9th write without rd -> o_ovf=1 and the 8 rows read back unchanged, in order.
REQ-036 SHALL cover write-while-full with read: all columns full, wr=1111 and rd in the same cycle -> both accepted, counts stay 8, o_ovf=0.
REQ-037 SHALL cover underflow: rd while empty -> o_udf=1, o_out_vld=0; clr_err -> o_udf=0.
REQ-038 SHALL cover wrap and almost-full: afull_thresh=6, stream 20 rows with rd every cycle -> in-order data across the pointer wrap; o_afull tracks count >= 6.
REQ-039 SHALL cover mid-stream reset: reset with 5 rows stored -> next cycle o_valid=0, o_rows=0, out=0, flags=0.
